// File: rtl/rc4_crack_core.sv
// RC4 brute-force key search engine: for each candidate key it runs S init, KSA and PRGA
// against external S RAM / ciphertext ROM / plaintext RAM and checks every byte against a character class.
`timescale 1ns/1ps
module rc4_crack_core #(
   parameter int         KEY_BYTES   = 3,
   parameter int         KEY_BITS    = 22,
   parameter int         MSG_LEN     = 32,
   parameter int         MSG_AW      = $clog2(MSG_LEN),
   parameter logic [7:0] CHAR_LO     = 8'd97,
   parameter logic [7:0] CHAR_HI     = 8'd122,
   parameter bit         ALLOW_SPACE = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [KEY_BITS-1:0]    key_start,
   input  logic [KEY_BITS-1:0]    key_end,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [8*KEY_BYTES-1:0] key_cur,
   output logic [8*KEY_BYTES-1:0] key_out,
   output logic [7:0]             s_addr,
   output logic [7:0]             s_wrdata,
   output logic                   s_wren,
   input  logic [7:0]             s_rddata,
   output logic [MSG_AW-1:0]      em_addr,
   input  logic [7:0]             em_rddata,
   output logic [MSG_AW-1:0]      dm_addr,
   output logic [7:0]             dm_wrdata,
   output logic                   dm_wren
);

   localparam int                  KW       = 8*KEY_BYTES;
   localparam int                  KB_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KB_W-1:0]     KB_LAST  = KB_W'(KEY_BYTES-1);
   localparam logic [MSG_AW-1:0]   K_LAST   = MSG_AW'(MSG_LEN-1);
   localparam logic [KEY_BITS-1:0] KEY_ONES = '1;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_PRGA, S_NEXT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, em_q, em_d;
   logic [MSG_AW-1:0]   k_q, k_d;
   logic [2:0]          sub_q, sub_d;
   logic [KB_W-1:0]     kb_q, kb_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [KW-1:0]       key_out_q, key_out_d;
   logic                found_q, found_d;
   logic [KW-1:0]       key_ext;
   logic [7:0]          key_byte;
   logic [7:0]          plain;

   function automatic logic byte_ok(input logic [7:0] b);
      return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (ALLOW_SPACE && (b == 8'd32));
   endfunction

   // Byte 0 is the most significant key byte.
   function automatic logic [7:0] key_byte_sel(input logic [KW-1:0] k, input logic [KB_W-1:0] n);
      logic [7:0] r;
      r = 8'd0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (n == KB_W'(b)) r = k[8*(KEY_BYTES-1-b) +: 8];
      end
      return r;
   endfunction

   assign key_ext = KW'(key_q);
   assign key_cur = key_ext;
   assign key_out = key_out_q;
   assign found   = found_q;
   assign busy    = (state_q == S_INIT) || (state_q == S_KSA) ||
                    (state_q == S_PRGA) || (state_q == S_NEXT);
   assign done    = (state_q == S_DONE);

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      si_d      = si_q;
      sj_d      = sj_q;
      em_d      = em_q;
      k_d       = k_q;
      sub_d     = sub_q;
      kb_d      = kb_q;
      key_d     = key_q;
      key_out_d = key_out_q;
      found_d   = found_q;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      em_addr   = '0;
      dm_addr   = '0;
      dm_wrdata = 8'd0;
      dm_wren   = 1'b0;
      plain     = s_rddata ^ em_q;
      key_byte  = key_byte_sel(key_ext, kb_q);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_INIT;
               key_d   = key_start;
               found_d = 1'b0;
               i_d     = 8'd0;
            end
         end
         S_INIT: begin
            s_addr   = i_q;
            s_wrdata = i_q;
            s_wren   = 1'b1;
            i_d      = i_q + 8'd1;
            if (i_q == 8'd255) begin
               state_d = S_KSA;
               j_d     = 8'd0;
               sub_d   = 3'd0;
               kb_d    = '0;
            end
         end
         S_KSA: begin
            case (sub_q)
               3'd0: begin
                  s_addr = i_q;
                  sub_d  = 3'd1;
               end
               3'd1: begin
                  si_d   = s_rddata;
                  j_d    = j_q + s_rddata + key_byte;
                  s_addr = j_d;
                  sub_d  = 3'd2;
               end
               3'd2: begin
                  s_addr   = i_q;
                  s_wrdata = s_rddata;
                  s_wren   = 1'b1;
                  sub_d    = 3'd3;
               end
               default: begin
                  s_addr   = j_q;
                  s_wrdata = si_q;
                  s_wren   = 1'b1;
                  sub_d    = 3'd0;
                  i_d      = i_q + 8'd1;
                  kb_d     = (kb_q == KB_LAST) ? '0 : kb_q + 1'b1;
                  if (i_q == 8'd255) begin
                     state_d = S_PRGA;
                     i_d     = 8'd0;
                     j_d     = 8'd0;
                     k_d     = '0;
                  end
               end
            endcase
         end
         S_PRGA: begin
            case (sub_q)
               3'd0: begin
                  i_d    = i_q + 8'd1;
                  s_addr = i_d;
                  sub_d  = 3'd1;
               end
               3'd1: begin
                  si_d   = s_rddata;
                  j_d    = j_q + s_rddata;
                  s_addr = j_d;
                  sub_d  = 3'd2;
               end
               3'd2: begin
                  sj_d     = s_rddata;
                  s_addr   = i_q;
                  s_wrdata = s_rddata;
                  s_wren   = 1'b1;
                  sub_d    = 3'd3;
               end
               3'd3: begin
                  s_addr   = j_q;
                  s_wrdata = si_q;
                  s_wren   = 1'b1;
                  em_addr  = k_q;
                  sub_d    = 3'd4;
               end
               3'd4: begin
                  s_addr = si_q + sj_q;
                  em_d   = em_rddata;
                  sub_d  = 3'd5;
               end
               default: begin
                  // Plaintext is always stored, even when it ends this key.
                  dm_addr   = k_q;
                  dm_wrdata = plain;
                  dm_wren   = 1'b1;
                  sub_d     = 3'd0;
                  if (!byte_ok(plain)) begin
                     state_d = S_NEXT;
                  end else if (k_q == K_LAST) begin
                     state_d   = S_DONE;
                     found_d   = 1'b1;
                     key_out_d = key_ext;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end
            endcase
         end
         S_NEXT: begin
            // ">=" also ends a search whose start lies above its end after one key.
            if ((key_q >= key_end) || (key_q == KEY_ONES)) begin
               state_d = S_DONE;
            end else begin
               key_d   = key_q + 1'b1;
               state_d = S_INIT;
               i_d     = 8'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (stop) begin
         state_d   = S_IDLE;
         key_d     = key_q;
         key_out_d = key_out_q;
         found_d   = found_q;
         s_wren    = 1'b0;
         dm_wren   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         i_q       <= 8'd0;
         j_q       <= 8'd0;
         si_q      <= 8'd0;
         sj_q      <= 8'd0;
         em_q      <= 8'd0;
         k_q       <= '0;
         sub_q     <= 3'd0;
         kb_q      <= '0;
         key_q     <= '0;
         key_out_q <= '0;
         found_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         si_q      <= si_d;
         sj_q      <= sj_d;
         em_q      <= em_d;
         k_q       <= k_d;
         sub_q     <= sub_d;
         kb_q      <= kb_d;
         key_q     <= key_d;
         key_out_q <= key_out_d;
         found_q   <= found_d;
      end
   end

endmodule

// File: tb/tb_rc4_crack_core.sv
// Directed bench for rc4_crack_core: two instances (wide key / narrow key without space) with behavioural memories.
`timescale 1ns/1ps
module tb_rc4_crack_core;

   localparam int ML = 8;

   logic clk;
   logic reset;
   int   n_cmp, n_bad;

   logic        start0, stop0, busy0, done0, found0, s_wren0, dm_wren0;
   logic [21:0] ks0, ke0;
   logic [23:0] key_cur0, key_out0;
   logic [7:0]  s_addr0, s_wrdata0, s_rddata0, em_rddata0, dm_wrdata0;
   logic [2:0]  em_addr0, dm_addr0;

   logic        start1, stop1, busy1, done1, found1, s_wren1, dm_wren1;
   logic [3:0]  ks1, ke1;
   logic [23:0] key_cur1, key_out1;
   logic [7:0]  s_addr1, s_wrdata1, s_rddata1, em_rddata1, dm_wrdata1;
   logic [2:0]  em_addr1, dm_addr1;

   logic [7:0] smem0 [256];
   logic [7:0] smem1 [256];
   logic [7:0] ct0 [ML];
   logic [7:0] ct1 [ML];
   logic [7:0] dm0 [ML];
   logic [7:0] dm1 [ML];
   logic [7:0] pt0 [ML] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
   logic [7:0] pt1 [ML] = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rc4_crack_core #(.KEY_BYTES(3), .KEY_BITS(22), .MSG_LEN(ML), .ALLOW_SPACE(1'b1)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .stop(stop0),
      .key_start(ks0), .key_end(ke0), .busy(busy0), .done(done0), .found(found0),
      .key_cur(key_cur0), .key_out(key_out0),
      .s_addr(s_addr0), .s_wrdata(s_wrdata0), .s_wren(s_wren0), .s_rddata(s_rddata0),
      .em_addr(em_addr0), .em_rddata(em_rddata0),
      .dm_addr(dm_addr0), .dm_wrdata(dm_wrdata0), .dm_wren(dm_wren0));

   rc4_crack_core #(.KEY_BYTES(3), .KEY_BITS(4), .MSG_LEN(ML), .ALLOW_SPACE(1'b0)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .stop(stop1),
      .key_start(ks1), .key_end(ke1), .busy(busy1), .done(done1), .found(found1),
      .key_cur(key_cur1), .key_out(key_out1),
      .s_addr(s_addr1), .s_wrdata(s_wrdata1), .s_wren(s_wren1), .s_rddata(s_rddata1),
      .em_addr(em_addr1), .em_rddata(em_rddata1),
      .dm_addr(dm_addr1), .dm_wrdata(dm_wrdata1), .dm_wren(dm_wren1));

   always @(posedge clk) begin
      if (s_wren0) smem0[s_addr0] <= s_wrdata0;
      s_rddata0  <= smem0[s_addr0];
      em_rddata0 <= ct0[em_addr0];
      if (dm_wren0) dm0[dm_addr0] <= dm_wrdata0;
      if (s_wren1) smem1[s_addr1] <= s_wrdata1;
      s_rddata1  <= smem1[s_addr1];
      em_rddata1 <= ct1[em_addr1];
      if (dm_wren1) dm1[dm_addr1] <= dm_wrdata1;
   end

   // Textbook RC4: n-th keystream byte for a 3-byte key, byte 0 = MSB.
   function automatic logic [7:0] rc4_byte(input logic [23:0] key, input int n);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] t, r;
      int i, j;
      kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      j = 0;
      for (int a = 0; a < 256; a++) begin
         j = (j + int'(s[a]) + int'(kb[a % 3])) % 256;
         t = s[a]; s[a] = s[j]; s[j] = t;
      end
      i = 0; j = 0; r = 8'd0;
      for (int m = 0; m <= n; m++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         r = s[(int'(s[i]) + int'(s[j])) % 256];
      end
      return r;
   endfunction

   function automatic int fail_idx(input logic [23:0] key, input bit use1);
      logic [7:0] b;
      for (int m = 0; m < ML; m++) begin
         b = rc4_byte(key, m) ^ (use1 ? ct1[m] : ct0[m]);
         if (!(((b >= 8'd97) && (b <= 8'd122)) || (!use1 && (b == 8'd32)))) return m;
      end
      return ML;
   endfunction

   task automatic expect_search(input logic [23:0] kstart, input logic [23:0] kend,
                                input logic [23:0] kmax, input bit use1, output int cyc,
                                output bit fnd, output logic [23:0] kout, output logic [23:0] klast);
      logic [23:0] k;
      int f;
      k = kstart; cyc = 0; fnd = 1'b0; kout = 24'd0; klast = kstart;
      for (int n = 0; n < 300; n++) begin
         f = fail_idx(k, use1);
         klast = k;
         if (f == ML) begin
            cyc += 1280 + 6*ML; fnd = 1'b1; kout = k;
            break;
         end
         cyc += 1280 + 6*(f + 1) + 1;
         if ((k >= kend) || (k == kmax)) break;
         k = k + 24'd1;
      end
   endtask

   task automatic pulse_start0(input logic [21:0] a, input logic [21:0] b);
      ks0 = a; ke0 = b; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic pulse_start1(input logic [3:0] a, input logic [3:0] b);
      ks1 = a; ke1 = b; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait_done0(output int cyc, output bit to);
      cyc = 0;
      for (int g = 0; g < 40000 && !done0; g++) begin
         if (busy0) cyc++;
         @(negedge clk);
      end
      to = !done0;
   endtask

   task automatic wait_done1(output int cyc, output bit to);
      cyc = 0;
      for (int g = 0; g < 40000 && !done1; g++) begin
         if (busy1) cyc++;
         @(negedge clk);
      end
      to = !done1;
   endtask

   task automatic test_reset;
      n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rst_busy_in_reset: got %b want 0", busy0); end
      n_cmp++; if (s_wren0 !== 1'b0) begin n_bad++; $display("FAIL rst_swren_in_reset: got %b want 0", s_wren0); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done0); end
      n_cmp++; if (found0 !== 1'b0) begin n_bad++; $display("FAIL rst_found: got %b want 0", found0); end
      n_cmp++; if (key_cur0 !== 24'h0) begin n_bad++; $display("FAIL rst_key_cur: got %h want 000000", key_cur0); end
      n_cmp++; if (key_out0 !== 24'h0) begin n_bad++; $display("FAIL rst_key_out: got %h want 000000", key_out0); end
      n_cmp++; if (s_addr0 !== 8'h0) begin n_bad++; $display("FAIL rst_s_addr: got %h want 00", s_addr0); end
      n_cmp++; if (dm_wren0 !== 1'b0) begin n_bad++; $display("FAIL rst_dm_wren: got %b want 0", dm_wren0); end
      n_cmp++; if (em_addr0 !== 3'd0) begin n_bad++; $display("FAIL rst_em_addr: got %h want 0", em_addr0); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy1: got %b want 0", busy1); end
   endtask

   task automatic test_single_key;
      int cyc; bit to;
      pulse_start0(22'h249, 22'h249);
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL single_busy_t1: got %b want 1", busy0); end
      n_cmp++; if ({s_wren0, s_addr0} !== 9'h100) begin n_bad++; $display("FAIL single_first_write: got wren=%b addr=%h want 1/00", s_wren0, s_addr0); end
      n_cmp++; if (key_cur0 !== 24'h000249) begin n_bad++; $display("FAIL single_key_cur: got %h want 000249", key_cur0); end
      wait_done0(cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: done never rose"); end
      n_cmp++; if (cyc !== 1328) begin n_bad++; $display("FAIL single_cycles: got %0d want 1328", cyc); end
      n_cmp++; if (found0 !== 1'b1) begin n_bad++; $display("FAIL single_found: got %b want 1", found0); end
      n_cmp++; if (key_out0 !== 24'h000249) begin n_bad++; $display("FAIL single_key_out: got %h want 000249", key_out0); end
      for (int b = 0; b < ML; b++) begin
         n_cmp++; if (dm0[b] !== pt0[b]) begin n_bad++; $display("FAIL single_dm[%0d]: got %h want %h", b, dm0[b], pt0[b]); end
      end
      repeat (3) @(negedge clk);
      n_cmp++; if ({done0, busy0} !== 2'b10) begin n_bad++; $display("FAIL single_done_level: got done/busy=%b want 10", {done0, busy0}); end
   endtask

   task automatic test_search_found;
      int cyc, ecyc; bit to, efnd; logic [23:0] ekout, eklast;
      expect_search(24'h240, 24'h2FF, 24'h3FFFFF, 1'b0, ecyc, efnd, ekout, eklast);
      pulse_start0(22'h240, 22'h2FF);
      wait_done0(cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL found_timeout: done never rose"); end
      n_cmp++; if (cyc !== ecyc) begin n_bad++; $display("FAIL found_cycles: got %0d want %0d", cyc, ecyc); end
      n_cmp++; if (found0 !== 1'b1) begin n_bad++; $display("FAIL found_flag: got %b want 1", found0); end
      n_cmp++; if (key_out0 !== 24'h000249) begin n_bad++; $display("FAIL found_key_out: got %h want 000249", key_out0); end
      for (int b = 0; b < ML; b++) begin
         n_cmp++; if (dm0[b] !== pt0[b]) begin n_bad++; $display("FAIL found_dm[%0d]: got %h want %h", b, dm0[b], pt0[b]); end
      end
   endtask

   task automatic test_search_exhaust;
      int cyc, ecyc; bit to, efnd; logic [23:0] ekout, eklast;
      expect_search(24'h240, 24'h248, 24'h3FFFFF, 1'b0, ecyc, efnd, ekout, eklast);
      pulse_start0(22'h240, 22'h248);
      wait_done0(cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL exhaust_timeout: done never rose"); end
      n_cmp++; if (cyc !== ecyc) begin n_bad++; $display("FAIL exhaust_cycles: got %0d want %0d", cyc, ecyc); end
      n_cmp++; if (found0 !== 1'b0) begin n_bad++; $display("FAIL exhaust_found: got %b want 0", found0); end
      n_cmp++; if (key_cur0 !== 24'h000248) begin n_bad++; $display("FAIL exhaust_key_cur: got %h want 000248", key_cur0); end
   endtask

   task automatic test_reset_mid_ksa;
      int cyc; bit to;
      pulse_start0(22'h249, 22'h249);
      repeat (500) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if ({busy0, done0, found0} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {busy0, done0, found0}); end
      n_cmp++; if (key_cur0 !== 24'h0) begin n_bad++; $display("FAIL rstmid_key_cur: got %h want 000000", key_cur0); end
      n_cmp++; if ({s_wren0, s_addr0, s_wrdata0} !== 17'h0) begin n_bad++; $display("FAIL rstmid_sport: got wren=%b addr=%h data=%h want 0", s_wren0, s_addr0, s_wrdata0); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pulse_start0(22'h249, 22'h249);
      n_cmp++; if ({key_cur0, s_wren0, s_addr0} !== {24'h000249, 1'b1, 8'h00}) begin n_bad++; $display("FAIL rstmid_restart: got key=%h wren=%b addr=%h want 000249/1/00", key_cur0, s_wren0, s_addr0); end
      wait_done0(cyc, to);
      n_cmp++; if ({to, found0, cyc} !== {1'b0, 1'b1, 32'd1328}) begin n_bad++; $display("FAIL rstmid_rerun: got to=%b found=%b cyc=%0d want 0/1/1328", to, found0, cyc); end
   endtask

   task automatic test_stop_prga;
      int cyc; bit to;
      pulse_start0(22'h249, 22'h249);
      repeat (1282) @(negedge clk);
      n_cmp++; if (s_wren0 !== 1'b1) begin n_bad++; $display("FAIL stop_pre_write: got %b want 1", s_wren0); end
      stop0 = 1'b1;
      #1;
      n_cmp++; if ({s_wren0, dm_wren0} !== 2'b00) begin n_bad++; $display("FAIL stop_wren_drop: got %b want 00", {s_wren0, dm_wren0}); end
      @(negedge clk);
      stop0 = 1'b0;
      n_cmp++; if ({busy0, done0} !== 2'b00) begin n_bad++; $display("FAIL stop_idle: got busy/done=%b want 00", {busy0, done0}); end
      n_cmp++; if (key_cur0 !== 24'h000249) begin n_bad++; $display("FAIL stop_key_hold: got %h want 000249", key_cur0); end
      pulse_start0(22'h249, 22'h249);
      wait_done0(cyc, to);
      n_cmp++; if ({to, found0, cyc} !== {1'b0, 1'b1, 32'd1328}) begin n_bad++; $display("FAIL stop_rerun: got to=%b found=%b cyc=%0d want 0/1/1328", to, found0, cyc); end
      n_cmp++; if (key_out0 !== 24'h000249) begin n_bad++; $display("FAIL stop_key_out: got %h want 000249", key_out0); end
   endtask

   task automatic test_start_while_busy;
      pulse_start0(22'h249, 22'h249);
      repeat (10) @(negedge clk);
      pulse_start0(22'h240, 22'h2FF);
      repeat (3) @(negedge clk);
      n_cmp++; if (key_cur0 !== 24'h000249) begin n_bad++; $display("FAIL busy_start_key: got %h want 000249", key_cur0); end
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL busy_start_busy: got %b want 1", busy0); end
      stop0 = 1'b1;
      @(negedge clk);
      stop0 = 1'b0;
      n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL busy_start_abort: got %b want 0", busy0); end
   endtask

   task automatic test_no_space;
      int cyc; bit to;
      pulse_start1(4'h5, 4'h5);
      wait_done1(cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL nospace_timeout: done never rose"); end
      n_cmp++; if (cyc !== 1299) begin n_bad++; $display("FAIL nospace_cycles: got %0d want 1299", cyc); end
      n_cmp++; if (found1 !== 1'b0) begin n_bad++; $display("FAIL nospace_found: got %b want 0", found1); end
      n_cmp++; if (key_cur1 !== 24'h000005) begin n_bad++; $display("FAIL nospace_key_cur: got %h want 000005", key_cur1); end
      n_cmp++; if ({dm1[0], dm1[1], dm1[2]} !== 24'h616220) begin n_bad++; $display("FAIL nospace_dm: got %h%h%h want 616220", dm1[0], dm1[1], dm1[2]); end
      n_cmp++; if (key_out1 !== 24'h0) begin n_bad++; $display("FAIL nospace_key_out: got %h want 000000", key_out1); end
   endtask

   task automatic test_no_wrap;
      int cyc, ecyc; bit to, efnd; logic [23:0] ekout, eklast;
      expect_search(24'hE, 24'h1, 24'hF, 1'b1, ecyc, efnd, ekout, eklast);
      pulse_start1(4'hE, 4'h1);
      wait_done1(cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL nowrap_timeout: done never rose"); end
      n_cmp++; if (cyc !== ecyc) begin n_bad++; $display("FAIL nowrap_cycles: got %0d want %0d", cyc, ecyc); end
      n_cmp++; if (found1 !== 1'b0) begin n_bad++; $display("FAIL nowrap_found: got %b want 0", found1); end
      n_cmp++; if (key_cur1 !== 24'h00000E) begin n_bad++; $display("FAIL nowrap_key_cur: got %h want 00000e", key_cur1); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      reset = 1'b1;
      start0 = 1'b0; stop0 = 1'b0; ks0 = '0; ke0 = '0;
      start1 = 1'b0; stop1 = 1'b0; ks1 = '0; ke1 = '0;
      for (int b = 0; b < ML; b++) begin
         ct0[b] = pt0[b] ^ rc4_byte(24'h000249, b);
         ct1[b] = pt1[b] ^ rc4_byte(24'h000005, b);
      end
      repeat (3) @(negedge clk);
      test_reset;
      test_single_key;
      test_search_found;
      test_search_exhaust;
      test_reset_mid_ksa;
      test_stop_prga;
      test_start_while_busy;
      test_no_space;
      test_no_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
